bcd_cascade_counter: RTL and testbench
======================================

Name: bcd_cascade_counter

Overview:
- Parametrised N-digit cascaded BCD counter with a programmable terminal count.
- Successor to the fixed 4-digit 0000..9675 counter/controller pair: the digit registers, ripple enables and terminal detection live in one block.
- Adds up/down counting, wrap or stop-at-terminal mode, parallel load with validation, and a registered wrap pulse.
- Sits between the tick/debounce logic and the 7-segment display driver.

Parameters:
- N_DIGITS, 4, number of BCD digits, 1..8.
- TERMINAL, 32'h0000_9675, packed BCD terminal value; low N_DIGITS*4 bits used; every nibble must be ≤9 (elaboration check).
- STOP_MODE, 0, 0 = wrap at terminal, 1 = hold at terminal (up) or at 0 (down) until clr/load.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous clear request (debounced reset button), active-high.
- ena  in  1  count tick, one-cycle pulse.
- up_dn  in  1  1 = count up, 0 = count down; sampled with ena.
- load  in  1  parallel load strobe.
- load_val  in  N_DIGITS*4  packed BCD load value.
- q  out  N_DIGITS*4  packed BCD count, digit 0 in bits [3:0].
- dig_ena  out  N_DIGITS  per-digit step enable for the current cycle (bit 0 = ena).
- tc  out  1  combinational: q==TERMINAL when up_dn=1, q==0 when up_dn=0.
- wrap  out  1  registered one-cycle pulse, the cycle after a wrap/stop event.
- done  out  1  sticky, STOP_MODE=1 only: counter reached its end value via a count step.
- load_err  out  1  registered one-cycle pulse: load rejected.

Behaviour:
- Reset: rst=1 at a clock edge → q=0, wrap=0, done=0, load_err=0. rst overrides every other input.
- Priority per edge: rst > clr > load > ena.
- clr: q=0, done=0, wrap=0. load_err=0 this cycle.
- load:
  - Accepted when every nibble ≤9 and load_val ≤ TERMINAL (unsigned comparison on packed BCD is valid): q=load_val, done=0.
  - Otherwise q unchanged and load_err=1 for one cycle.
  - ena in the same cycle is ignored.
- Count step, ena=1 with no higher-priority input:
  - Up: digit i steps when ena and digits 0..i-1 are all 9. A stepping digit goes 9→0, otherwise +1.
  - Down: digit i steps when ena and digits 0..i-1 are all 0. A stepping digit goes 0→9, otherwise −1.
  - Single-cycle latency: q updates at the edge where ena is sampled.
  - dig_ena reflects this ripple combinationally.
- Terminal, up (q==TERMINAL and ena):
  - STOP_MODE=0 → q=0, wrap=1 next cycle.
  - STOP_MODE=1 → q holds, done=1, wrap=1 on the first such event only.
- Terminal, down (q==0 and ena):
  - STOP_MODE=0 → q=TERMINAL, wrap=1.
  - STOP_MODE=1 → q holds, done=1, wrap=1 on the first such event only.
- done=1 blocks all count steps until clr, load or rst.
- Direction change while done=1 does not clear done.
- q is always valid BCD and ≤ TERMINAL; no intermediate invalid value is ever registered.
- ena held high steps once per cycle; no internal edge detection.
- All outputs glitch-free registered except tc and dig_ena.

Decomposition:
- Shared package bcd_pkg:
  - BCD_MAX = 4'd9.
  - Function bcd_valid(vector) for the nibble check.
  - Parameter check macro for TERMINAL.
- Sub-module bcd_digit, one per digit:
  - 4-bit register.
  - Inputs step, up_dn, clr, load, load_nib.
  - Outputs q_nib, is_max (==9), is_min (==0).
- Top-level logic:
  - Generate loop for the enable ripple.
  - Terminal compare.
  - Wrap/done/load_err registers.

Test Plan:
- Reset mid-count: q=0x1234, rst=1 for one edge → q=0x0000, wrap=0, done=0. A simultaneous load is ignored.
- Up ripple: load 0x0999, ena pulse → q=0x1000, dig_ena=4'b1111 during that cycle.
- Wrap at terminal (defaults): load 0x9675, up, ena → q=0x0000, wrap=1 exactly one cycle later. Next ena → q=0x0001.
- Down wrap: q=0x0000, up_dn=0, ena → q=0x9675, wrap pulse. Next ena → 0x9674.
- STOP_MODE=1: count up to 0x9675 → done=1, single wrap pulse. Further 5 ena pulses → q stays 0x9675. clr → q=0, done=0.
- Load validation:
  - load_val=0x9A00 → load_err=1, q unchanged.
  - load_val=0x9700 → load_err=1 (exceeds TERMINAL).
  - load_val=0x5000 with ena=1 same cycle → q=0x5000.
  - clr and load in the same cycle → q=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the cascaded BCD counter.
package bcd_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned BCD_MAX_DIG = 8;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

  // True when each of the low n_digits nibbles of v holds a decimal digit.
  function automatic logic bcd_valid(input logic [31:0] v, input int unsigned n_digits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < BCD_MAX_DIG; i++) begin
      if ((i < n_digits) && (v[i*BCD_W +: BCD_W] > BCD_MAX)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with clear, parallel load and up/down step.
// Ports: clk, rst (sync, active-high), clr, load/load_nib, step, up_dn;
//        q_nib (registered digit), is_max (==9), is_min (==0).
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       step,
  input  logic       up_dn,
  output logic [3:0] q_nib,
  output logic       is_max,
  output logic       is_min
);

  logic [3:0] nib_q, nib_d;

  // Next digit value: clear beats load beats step.
  always_comb begin
    nib_d = nib_q;
    if (clr) begin
      nib_d = 4'd0;
    end else if (load) begin
      nib_d = load_nib;
    end else if (step) begin
      if (up_dn) nib_d = (nib_q == BCD_MAX) ? 4'd0 : nib_q + 4'd1;
      else       nib_d = (nib_q == 4'd0) ? BCD_MAX : nib_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) nib_q <= 4'd0;
    else     nib_q <= nib_d;
  end

  assign q_nib  = nib_q;
  assign is_max = (nib_q == BCD_MAX);
  assign is_min = (nib_q == 4'd0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// N-digit cascaded BCD counter with programmable terminal count,
// up/down, wrap or stop-at-end mode, validated parallel load.
// Ports: clk, rst (sync, active-high), clr, ena, up_dn, load, load_val;
//        q (registered count), dig_ena (comb ripple), tc (comb terminal),
//        wrap/done/load_err (registered status).
module bcd_cascade_counter
  import bcd_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 4,
  parameter logic [31:0] TERMINAL  = 32'h0000_9675,
  parameter bit          STOP_MODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  ena,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [N_DIGITS*4-1:0] load_val,
  output logic [N_DIGITS*4-1:0] q,
  output logic [N_DIGITS-1:0]   dig_ena,
  output logic                  tc,
  output logic                  wrap,
  output logic                  done,
  output logic                  load_err
);

  localparam int unsigned W    = N_DIGITS * BCD_W;
  localparam logic [W-1:0] TERM = TERMINAL[W-1:0];

  // Elaboration-time parameter sanity.
  if ((N_DIGITS < 1) || (N_DIGITS > BCD_MAX_DIG)) begin : g_bad_ndig
    $error("N_DIGITS must be 1..8");
  end
  if (!bcd_valid(TERMINAL, N_DIGITS)) begin : g_bad_term
    $error("TERMINAL has a nibble above 9");
  end

  logic [N_DIGITS-1:0] is_max, is_min;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;
  logic                load_err_q, load_err_d;
  logic                count_go, term_evt, load_ok;
  logic                dig_clr, dig_load;

  // Enable ripple: digit i steps when every lower digit is at its rollover value.
  always_comb begin
    logic run;
    run = ena;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      dig_ena[i] = run;
      run = run & (up_dn ? is_max[i] : is_min[i]);
    end
  end

  assign tc = up_dn ? (q == TERM) : (q == '0);

  assign load_ok  = bcd_valid(32'(load_val), N_DIGITS) && (load_val <= TERM);
  assign count_go = ena & ~clr & ~load & ~done_q;
  assign term_evt = count_go & tc;

  // Terminal events reuse the clear/load paths so no out-of-range value is registered.
  assign dig_clr  = clr | (term_evt & up_dn & ~STOP_MODE);
  assign dig_load = (load & load_ok) | (term_evt & ~up_dn & ~STOP_MODE);

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (dig_clr),
      .load     (dig_load),
      .load_nib (load ? load_val[i*BCD_W +: BCD_W] : TERM[i*BCD_W +: BCD_W]),
      .step     (dig_ena[i] & count_go & ~tc),
      .up_dn    (up_dn),
      .q_nib    (q[i*BCD_W +: BCD_W]),
      .is_max   (is_max[i]),
      .is_min   (is_min[i])
    );
  end

  // Status next-state.
  always_comb begin
    wrap_d     = term_evt;
    load_err_d = ~clr & load & ~load_ok;
    done_d     = done_q;
    if (clr)                  done_d = 1'b0;
    else if (load)            done_d = load_ok ? 1'b0 : done_q;
    else if (STOP_MODE && term_evt) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for bcd_cascade_counter: wrap-mode and stop-mode instances share stimulus.
module tb_bcd_cascade_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1, clr = 1'b0, ena = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [15:0] load_val = 16'h0;

  logic [15:0] q0, q1;
  logic [3:0]  dig0, dig1;
  logic        tc0, tc1, wrap0, wrap1, done0, done1, lerr0, lerr1;

  always #5 clk = ~clk;

  bcd_cascade_counter #(.N_DIGITS(4), .TERMINAL(32'h0000_9675), .STOP_MODE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .ena(ena), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q0), .dig_ena(dig0), .tc(tc0), .wrap(wrap0),
    .done(done0), .load_err(lerr0)
  );

  bcd_cascade_counter #(.N_DIGITS(4), .TERMINAL(32'h0000_9675), .STOP_MODE(1'b1)) u_stop (
    .clk(clk), .rst(rst), .clr(clr), .ena(ena), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q1), .dig_ena(dig1), .tc(tc1), .wrap(wrap1),
    .done(done1), .load_err(lerr1)
  );

  typedef struct {
    logic        rst, clr, ena, up_dn, load;
    logic [15:0] lv;
    logic        chk_c;
    logic [3:0]  dig;
    logic        tc;
    logic [15:0] q;
    logic        wrap, done, lerr;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic        wrap, done, lerr;
    string       tag;
  } exp_t;

  exp_t sb[$];
  vec_t main_tbl[$];
  vec_t stop_tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic r, logic c, logic e, logic u, logic l, logic [15:0] lv,
                              logic chk, logic [3:0] dig, logic t,
                              logic [15:0] qx, logic w, logic d, logic le);
    vec_t v;
    v.rst = r; v.clr = c; v.ena = e; v.up_dn = u; v.load = l; v.lv = lv;
    v.chk_c = chk; v.dig = dig; v.tc = t;
    v.q = qx; v.wrap = w; v.done = d; v.lerr = le;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one vector, check comb outputs before the edge, registered ones after.
  task automatic apply(input vec_t v, input bit stop, input string tag);
    exp_t e;
    @(negedge clk);
    rst = v.rst; clr = v.clr; ena = v.ena; up_dn = v.up_dn; load = v.load; load_val = v.lv;
    #1;
    if (v.chk_c) begin
      check({tag, ".dig_ena"}, 32'(stop ? dig1 : dig0), 32'(v.dig));
      check({tag, ".tc"}, 32'(stop ? tc1 : tc0), 32'(v.tc));
    end
    e.q = v.q; e.wrap = v.wrap; e.done = v.done; e.lerr = v.lerr; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".q"},        32'(stop ? q1 : q0),       32'(e.q));
    check({e.tag, ".wrap"},     32'(stop ? wrap1 : wrap0), 32'(e.wrap));
    check({e.tag, ".done"},     32'(stop ? done1 : done0), 32'(e.done));
    check({e.tag, ".load_err"}, 32'(stop ? lerr1 : lerr0), 32'(e.lerr));
  endtask

  initial begin
    //                 rst clr ena up ld  lv        chk dig      tc  q         w  d  le
    main_tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 4'b0000, 0, 16'h0000, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 1, 1, 16'h1234, 1, 4'b0000, 0, 16'h1234, 0, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 1, 1, 16'h5555, 0, 4'b0000, 0, 16'h0000, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0999, 0, 4'b0000, 0, 16'h0999, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 1, 4'b1111, 0, 16'h1000, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 1, 1, 16'h9675, 0, 4'b0000, 0, 16'h9675, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 1, 4'b0001, 1, 16'h0000, 1, 0, 0));
    main_tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 1, 4'b0001, 0, 16'h0001, 0, 0, 0));
    main_tbl.push_back(mk(0, 1, 0, 1, 0, 16'h0000, 0, 4'b0000, 0, 16'h0000, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 4'b1111, 1, 16'h9675, 1, 0, 0));
    main_tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 4'b0001, 0, 16'h9674, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 1, 1, 16'h9A00, 0, 4'b0000, 0, 16'h9674, 0, 0, 1));
    main_tbl.push_back(mk(0, 0, 0, 1, 1, 16'h9700, 0, 4'b0000, 0, 16'h9674, 0, 0, 1));
    main_tbl.push_back(mk(0, 0, 1, 1, 1, 16'h5000, 1, 4'b0001, 0, 16'h5000, 0, 0, 0));
    main_tbl.push_back(mk(0, 1, 0, 1, 1, 16'h1234, 0, 4'b0000, 0, 16'h0000, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 1, 1, 1, 16'h9A00, 0, 4'b0000, 0, 16'h0000, 0, 0, 1));
    main_tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 0, 4'b0000, 0, 16'h0001, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 0, 4'b0000, 0, 16'h0002, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 1, 1, 16'h9675, 0, 4'b0000, 0, 16'h9675, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 4'b0001, 0, 16'h9674, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 0, 1, 16'h1000, 0, 4'b0000, 0, 16'h1000, 0, 0, 0));
    main_tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 4'b1111, 0, 16'h0999, 0, 0, 0));

    // Stop-mode instance.
    stop_tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0000, 0, 4'b0000, 0, 16'h0000, 0, 0, 0));
    stop_tbl.push_back(mk(0, 0, 0, 1, 1, 16'h9673, 0, 4'b0000, 0, 16'h9673, 0, 0, 0));
    stop_tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 0, 4'b0000, 0, 16'h9674, 0, 0, 0));
    stop_tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 0, 4'b0000, 0, 16'h9675, 0, 0, 0));
    stop_tbl.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 1, 4'b0001, 1, 16'h9675, 1, 1, 0));

    for (int i = 0; i < main_tbl.size(); i++)
      apply(main_tbl[i], 1'b0, $sformatf("wrap[%0d]", i));

    for (int i = 0; i < stop_tbl.size(); i++)
      apply(stop_tbl[i], 1'b1, $sformatf("stop[%0d]", i));

    // Held at the end value: five more ticks, single wrap pulse already spent.
    for (int i = 0; i < 5; i++)
      apply(mk(0, 0, 1, 1, 0, 16'h0000, 0, 4'b0000, 0, 16'h9675, 0, 1, 0), 1'b1,
            $sformatf("stop_hold[%0d]", i));
    // Direction change does not release done.
    apply(mk(0, 0, 1, 0, 0, 16'h0000, 0, 4'b0000, 0, 16'h9675, 0, 1, 0), 1'b1, "stop_dirchg");
    apply(mk(0, 1, 0, 0, 0, 16'h0000, 0, 4'b0000, 0, 16'h0000, 0, 0, 0), 1'b1, "stop_clr");
    apply(mk(0, 0, 1, 0, 0, 16'h0000, 1, 4'b1111, 1, 16'h0000, 1, 1, 0), 1'b1, "stop_down_end");
    apply(mk(0, 0, 1, 0, 0, 16'h0000, 0, 4'b0000, 0, 16'h0000, 0, 1, 0), 1'b1, "stop_down_hold");
    // Rejected load leaves done set; accepted load clears it.
    apply(mk(0, 0, 0, 1, 1, 16'h9800, 0, 4'b0000, 0, 16'h0000, 0, 1, 1), 1'b1, "stop_badload");
    apply(mk(0, 0, 0, 1, 1, 16'h0005, 0, 4'b0000, 0, 16'h0005, 0, 0, 0), 1'b1, "stop_load");
    apply(mk(0, 0, 1, 1, 0, 16'h0000, 0, 4'b0000, 0, 16'h0006, 0, 0, 0), 1'b1, "stop_resume");

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
